// File: rtl/cnn_ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// cnn_ctrl_seq_pkg
// Shared types and constants for the CNN control sequencer and its packet
// decoder: the PE_state encoding, the CNTR_PACKET layout, the number of
// output-channel PEs and the packet field widths.
// -----------------------------------------------------------------------------
package cnn_ctrl_seq_pkg;

  localparam int OCP_NUM = 4;   // output-channel PEs (2-bit channel field)
  localparam int DATA_W  = 8;   // weight / write-bank data width
  localparam int ADDR_W  = 8;   // write-bank address width
  localparam int RADDR_W = 4;   // read-bank address width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CONV = 3'd2,
    POOL = 3'd3,
    RELU = 3'd4,
    DONE = 3'd5
  } pe_state_t;

  typedef struct packed {
    pe_state_t           PE_state;
    logic [DATA_W-1:0]   wrb_data;
    logic [ADDR_W-1:0]   wrb_addr;
    logic                wrb;
    logic [RADDR_W-1:0]  rdb_addr;
  } CNTR_PACKET;

endpackage

// File: rtl/cnn_wload_addr_gen.sv
// -----------------------------------------------------------------------------
// cnn_wload_addr_gen
// Channel / weight-index counters for the weight load phase. Produces the
// write-bank address {ch[1:0], 2'b00, idx[3:0]} of the beat currently on offer
// and flags the final beat of the load (last channel, last index).
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   clr    in   restart counting from channel 0, index 0
//   beat   in   a weight beat is accepted this cycle (advance counters)
//   addr   out  write address for the beat on offer
//   last   out  the beat on offer is the last one of the load
// -----------------------------------------------------------------------------
module cnn_wload_addr_gen
  import cnn_ctrl_seq_pkg::*;
#(
  parameter int N_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              beat,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [1:0] ch;
  logic [3:0] idx;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ch  <= '0;
      idx <= '0;
    end else if (beat) begin
      if (idx == 4'(N_W - 1)) begin
        idx <= '0;
        ch  <= ch + 2'd1;
      end else begin
        idx <= idx + 4'd1;
      end
    end
  end

  assign addr = {ch, 2'b00, idx};
  assign last = (ch == 2'(OCP_NUM - 1)) && (idx == 4'(N_W - 1));

endmodule

// File: rtl/cnn_ctrl_seq.sv
// -----------------------------------------------------------------------------
// cnn_ctrl_seq
// Layer-pass sequencer driving the CNTR_PACKET stream of the CNN PE/POOL/ReLU
// array. Per start: load OCP_NUM*N_W weights from a valid/ready stream, then
// run CONV (N_PIX read addresses) -> POOL (POOL_CYC cycles) -> RELU (1 cycle)
// once per output window, then a single DONE cycle.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   start      in   begin a pass (sampled only in IDLE)
//   skip_load  in   bypass LOAD, reuse resident weights (only when
//                   CNN_CTRL_WRELOAD_SKIP_EN is defined)
//   num_win    in   number of output windows, latched on start
//   w_valid    in   weight beat valid
//   w_data     in   weight value
//   w_ready    out  high in LOAD (decoded from state, no lag)
//   pk_out     out  registered control packet, one cycle behind the state
//   busy       out  state is not IDLE (decoded from state, no lag)
//   done       out  one-cycle pulse aligned with pk_out.PE_state == DONE
//
// Build option: define CNN_CTRL_WRELOAD_SKIP_EN to add the skip_load input.
// -----------------------------------------------------------------------------
module cnn_ctrl_seq
  import cnn_ctrl_seq_pkg::*;
#(
  parameter int N_W      = 16,
  parameter int N_PIX    = 16,
  parameter int POOL_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef CNN_CTRL_WRELOAD_SKIP_EN
  input  logic              skip_load,
`endif
  input  logic [7:0]        num_win,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  output CNTR_PACKET        pk_out,
  output logic              busy,
  output logic              done
);

  pe_state_t          state;
  logic [RADDR_W-1:0] pix;
  logic [7:0]         pool_cnt;
  logic [7:0]         win_cnt;
  logic [7:0]         num_win_q;

  logic               beat;
  logic               clr;
  logic               load_last;
  logic               skip;
  logic [ADDR_W-1:0]  wr_addr;

`ifdef CNN_CTRL_WRELOAD_SKIP_EN
  assign skip = skip_load;
`else
  assign skip = 1'b0;
`endif

  assign w_ready = (state == LOAD);
  assign busy    = (state != IDLE);
  assign beat    = w_ready & w_valid;
  assign clr     = (state == IDLE) & start;

  cnn_wload_addr_gen #(
    .N_W (N_W)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .beat  (beat),
    .addr  (wr_addr),
    .last  (load_last)
  );

  // State register and packet register: pk_out captures this cycle's
  // decisions, so it always trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pix       <= '0;
      pool_cnt  <= '0;
      win_cnt   <= '0;
      num_win_q <= '0;
      pk_out    <= '0;
      done      <= 1'b0;
    end else begin
      pk_out.PE_state <= state;
      pk_out.wrb      <= 1'b0;
      pk_out.rdb_addr <= '0;
      done            <= (state == DONE);

      case (state)
        IDLE: begin
          if (start) begin
            pix       <= '0;
            pool_cnt  <= '0;
            win_cnt   <= '0;
            num_win_q <= num_win;
            if (skip) state <= (num_win == 8'd0) ? DONE : CONV;
            else      state <= LOAD;
          end
        end

        LOAD: begin
          // Address and data are only refreshed on an accepted beat; gap
          // cycles keep the last written values on the bus.
          if (beat) begin
            pk_out.wrb      <= 1'b1;
            pk_out.wrb_data <= w_data;
            pk_out.wrb_addr <= wr_addr;
            if (load_last) state <= (num_win_q == 8'd0) ? DONE : CONV;
          end
        end

        CONV: begin
          pk_out.rdb_addr <= pix;
          if (pix == RADDR_W'(N_PIX - 1)) begin
            pix   <= '0;
            state <= POOL;
          end else begin
            pix <= pix + 1'b1;
          end
        end

        POOL: begin
          if (pool_cnt == 8'(POOL_CYC - 1)) begin
            pool_cnt <= '0;
            state    <= RELU;
          end else begin
            pool_cnt <= pool_cnt + 8'd1;
          end
        end

        RELU: begin
          win_cnt <= win_cnt + 8'd1;
          if (win_cnt + 8'd1 == num_win_q) state <= DONE;
          else                             state <= CONV;
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_cnn_ctrl_seq
// Scoreboard bench for cnn_ctrl_seq. Each pass pushes its expected per-cycle
// packet stream into a queue; a negedge monitor pops and compares one entry
// every cycle the DUT presents a non-IDLE packet or a done pulse.
// -----------------------------------------------------------------------------
module tb_cnn_ctrl_seq;
  import cnn_ctrl_seq_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] d;
    logic [7:0] a;
    logic       w;
    logic [3:0] r;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_win;
  logic       w_valid;
  logic [7:0] w_data;
  logic       w_ready;
  CNTR_PACKET pk_out;
  logic       busy;
  logic       done;
`ifdef CNN_CTRL_WRELOAD_SKIP_EN
  logic       skip_in;
`endif

  exp_t       exp_q[$];
  bit         vpat[$];
  int         checks = 0;
  int         errors = 0;
  int         mon_idx = 0;
  logic [7:0] held_d = 8'd0;
  logic [7:0] held_a = 8'd0;

  always #5 clk = ~clk;

  cnn_ctrl_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef CNN_CTRL_WRELOAD_SKIP_EN
    .skip_load (skip_in),
`endif
    .num_win   (num_win),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .pk_out    (pk_out),
    .busy      (busy),
    .done      (done)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic void push(int st, logic [7:0] d, logic [7:0] a, logic w,
                               logic [3:0] r, logic dn);
    exp_t e;
    e.st = 3'(st);
    e.d  = d;
    e.a  = a;
    e.w  = w;
    e.r  = r;
    e.dn = dn;
    exp_q.push_back(e);
  endfunction

  task automatic set_skip(input bit s);
`ifdef CNN_CTRL_WRELOAD_SKIP_EN
    skip_in = s;
`else
    if (s) $display("note: skip_load requested in a build without it");
`endif
  endtask

  // Expected packet stream of one pass. States: 1 LOAD, 2 CONV, 3 POOL,
  // 4 RELU, 5 DONE. Beat b goes to channel b/16 (address bits 7:6), index b%16.
  task automatic plan_pass(input int nw, input bit gaps, input bit skip);
    int beats;
    int j;
    vpat.delete();
    beats = 0;
    j = 0;
    if (!skip) begin
      while (beats < 64) begin
        if (!gaps || (j % 2 == 1)) begin
          held_d = 8'(beats);
          held_a = 8'((beats / 16) * 64 + (beats % 16));
          vpat.push_back(1'b1);
          push(1, held_d, held_a, 1'b1, 4'd0, 1'b0);
          beats++;
        end else begin
          vpat.push_back(1'b0);
          push(1, held_d, held_a, 1'b0, 4'd0, 1'b0);
        end
        j++;
      end
    end
    for (int w = 0; w < nw; w++) begin
      for (int p = 0; p < 16; p++) push(2, held_d, held_a, 1'b0, 4'(p), 1'b0);
      for (int p = 0; p < 4; p++)  push(3, held_d, held_a, 1'b0, 4'd0, 1'b0);
      push(4, held_d, held_a, 1'b0, 4'd0, 1'b0);
    end
    push(5, held_d, held_a, 1'b0, 4'd0, 1'b1);
  endtask

  // Drives one pass. cyc counts edges after edge E (the edge sampling start).
  // repulse_at: cycle at which start is re-pulsed with num_win=5 (-1: never).
  // reset_at: cycle at which reset is raised; returns one edge later.
  task automatic run_pass(input int nw, input bit skip, input int done_exp,
                          input int repulse_at, input int reset_at);
    int  cyc;
    int  beats;
    bit  seen;
    @(posedge clk); #1;
    start   = 1'b1;
    num_win = 8'(nw);
    set_skip(skip);
    @(posedge clk); #1;
    start = 1'b0;
    set_skip(1'b0);
    cyc   = 0;
    beats = 0;
    seen  = 1'b0;
    while (!seen && cyc < 600) begin
      if (cyc < vpat.size()) begin
        w_valid = vpat[cyc];
        w_data  = 8'(beats);
      end else begin
        w_valid = 1'b0;
      end
      start = (cyc == repulse_at);
      if (cyc == repulse_at) num_win = 8'd5;
      if (cyc == reset_at) reset = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (cyc - 1 < vpat.size() && vpat[cyc-1]) beats++;
      if (cyc == 1) begin
        chk("busy_first", 32'(busy), 32'd1);
        chk("w_ready_first", 32'(w_ready), skip ? 32'd0 : 32'd1);
      end
      if (reset_at >= 0 && cyc == reset_at + 1) return;
      if (done) seen = 1'b1;
    end
    w_valid = 1'b0;
    start   = 1'b0;
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: no done after %0d cycles, expected at %0d", cyc, done_exp);
    end else begin
      chk("done_cycle", 32'(cyc), 32'(done_exp));
      chk("busy_after_done", 32'(busy), 32'd0);
    end
    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: one expected entry per non-IDLE packet or done pulse.
  always @(negedge clk) begin : monitor
    exp_t a;
    exp_t e;
    if (pk_out.PE_state != IDLE || done) begin
      a.st = 3'(pk_out.PE_state);
      a.d  = pk_out.wrb_data;
      a.a  = pk_out.wrb_addr;
      a.w  = pk_out.wrb;
      a.r  = pk_out.rdb_addr;
      a.dn = done;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pkt_unexpected[%0d]: got st=%0d d=%0h a=%0h w=%0b r=%0d dn=%0b, expected none",
                 mon_idx, a.st, a.d, a.a, a.w, a.r, a.dn);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL pkt[%0d]: got st=%0d d=%0h a=%0h w=%0b r=%0d dn=%0b, expected st=%0d d=%0h a=%0h w=%0b r=%0d dn=%0b",
                   mon_idx, a.st, a.d, a.a, a.w, a.r, a.dn, e.st, e.d, e.a, e.w, e.r, e.dn);
        end
      end
      mon_idx++;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int remaining;
    reset   = 1'b1;
    start   = 1'b1;
    num_win = 8'd2;
    w_valid = 1'b0;
    w_data  = 8'd0;
    set_skip(1'b0);

    // Reset values, with start asserted throughout reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pk_out", 32'(pk_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_state", 32'(pk_out.PE_state), 32'd0);

    // Full pass, w_valid held high, two windows
    plan_pass(2, 1'b0, 1'b0);
    run_pass(2, 1'b0, 107, -1, -1);

    // Weight gaps: w_valid low on the first LOAD cycle, then toggling
    plan_pass(2, 1'b1, 1'b0);
    run_pass(2, 1'b0, 171, -1, -1);

    // Zero windows: LOAD straight to DONE
    plan_pass(0, 1'b0, 1'b0);
    run_pass(0, 1'b0, 65, -1, -1);

    // Start re-pulsed (num_win=5) during CONV is ignored
    plan_pass(2, 1'b0, 1'b0);
    run_pass(2, 1'b0, 107, 70, -1);

    // Reset during the 3rd CONV cycle: 64 LOAD + 2 CONV packets seen first
    plan_pass(2, 1'b0, 1'b0);
    remaining = exp_q.size() - 66;
    run_pass(2, 1'b0, 0, -1, 66);
    chk("midrst_pk_out", 32'(pk_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_consumed", 32'(exp_q.size()), 32'(remaining));
    exp_q.delete();
    held_d = 8'd0;
    held_a = 8'd0;
    reset  = 1'b0;
    w_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", 32'(busy), 32'd0);

`ifdef CNN_CTRL_WRELOAD_SKIP_EN
    // Skip LOAD: first packet is CONV, no wrb at all
    plan_pass(1, 1'b0, 1'b1);
    run_pass(1, 1'b1, 22, -1, -1);
`else
    // Fresh pass after the interrupted one reloads the bank
    plan_pass(1, 1'b0, 1'b0);
    run_pass(1, 1'b0, 86, -1, -1);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
